// File: rtl/move_uart_tx.sv
// Serial transmitter for one game move: sends HEADER, the move byte and, when
// MOVE_TX_CHECKSUM_EN is defined, a checksum byte (HEADER ^ move), each as UART 8N1.
module move_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tx_ready,
    input  logic [7:0] move,
    output logic       uart_tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef MOVE_TX_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_move;
    logic             r_tx;
    logic             r_done;
    logic             r_overrun;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       w_bit_nx;
    logic [1:0]       w_byte_nx;
    logic [7:0]       w_move_nx;
    logic             w_tx_nx;
    logic             w_done_nx;
    logic             w_overrun_nx;
    logic             w_bit_end;
    logic             w_busy;
    logic [7:0]       w_byte;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_bit_end = (r_cnt == CNT_LAST);

    // Byte currently on the wire, chosen by the byte index.
    always_comb begin
        w_byte = HEADER;
        case (r_byte_idx)
            2'd1:    w_byte = r_move;
`ifdef MOVE_TX_CHECKSUM_EN
            2'd2:    w_byte = HEADER ^ r_move;
`endif
            default: w_byte = HEADER;
        endcase
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_nx     = r_bit_idx;
        w_byte_nx    = r_byte_idx;
        w_move_nx    = r_move;
        w_done_nx    = 1'b0;
        w_overrun_nx = tx_ready && w_busy;
        w_cnt_nx     = (w_bit_end || !w_busy) ? '0 : r_cnt + CNT_W'(1);

        case (r_state)
            ST_IDLE: begin
                if (tx_ready) begin
                    w_state_nx = ST_START;
                    w_move_nx  = move;
                    w_byte_nx  = 2'd0;
                    w_bit_nx   = 3'd0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                    w_bit_nx   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = ST_STOP;
                    end else begin
                        w_bit_nx = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_START;
                        w_byte_nx  = r_byte_idx + 2'd1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Line level is registered from the next state so it changes on the
        // same edge as the state, giving exact bit periods with no glitches.
        case (w_state_nx)
            ST_START: w_tx_nx = 1'b0;
            ST_DATA:  w_tx_nx = w_byte[w_bit_nx];
            default:  w_tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_move     <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_bit_idx  <= w_bit_nx;
            r_byte_idx <= w_byte_nx;
            r_move     <= w_move_nx;
            r_tx       <= w_tx_nx;
            r_done     <= w_done_nx;
            r_overrun  <= w_overrun_nx;
        end
    end

    assign uart_tx = r_tx;
    assign busy    = w_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_move_uart_tx.sv
// Bench for move_uart_tx at CLKS_PER_BIT=4; expected line levels come from a
// queue built from the frame definition (bytes, 8N1 framing, LSB first).
module tb_move_uart_tx;

    localparam int N = 4;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef MOVE_TX_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int FRAME_CYC = NB * 10 * N;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       tx_ready = 1'b0;
    logic [7:0] move = 8'h00;
    logic       uart_tx;
    logic       busy;
    logic       done;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    logic [0:0] exp_q[$];

    move_uart_tx #(.CLKS_PER_BIT(N), .HEADER(HDR)) dut (
        .clk_in(clk_in), .reset(reset), .tx_ready(tx_ready), .move(move),
        .uart_tx(uart_tx), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (done === 1'b1) done_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic build_frame(input logic [7:0] m);
        logic [7:0] b[3];
        logic v;
        b[0] = HDR;
        b[1] = m;
        b[2] = HDR ^ m;
        exp_q.delete();
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s < 10; s++) begin
                if (s == 0) v = 1'b0;
                else if (s == 9) v = 1'b1;
                else v = b[k][s-1];
                for (int r = 0; r < N; r++) exp_q.push_back(v);
            end
        end
    endtask

    task automatic send_pulse(input logic [7:0] m);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        move = m;
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
        move = 8'($urandom_range(0, 255));
    endtask

    // Checks the first ncyc busy cycles of a frame carrying move m.
    task automatic check_frame(input logic [7:0] m, input int ncyc, input string name);
        logic exp;
        int bad;
        bad = 0;
        build_frame(m);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_in);
            exp = exp_q.pop_front();
            checks++;
            if (uart_tx !== exp || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                if (bad < 4)
                    $display("FAIL %s cyc=%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                             name, i, uart_tx, busy, done, exp);
                bad++;
            end
        end
    endtask

    task automatic check_done_cycle(input string name);
        @(negedge clk_in);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL %s done_cycle: busy=%b done=%b tx=%b, required 0 1 1", name, busy, done, uart_tx);
        end
        @(negedge clk_in);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        tx_ready = 1'b0;
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b ovr=%b, required 1 0 0 0", uart_tx, busy, done, overrun);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (busy !== 1'b0 || uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: busy=%b tx=%b, required 0 1", busy, uart_tx);
        end
    endtask

    task automatic test_fixed(input logic [7:0] m, input string name);
        int d0;
        d0 = done_cnt;
        send_pulse(m);
        check_frame(m, FRAME_CYC, name);
        check_done_cycle(name);
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d, required 1", name, done_cnt - d0);
        end
    endtask

    task automatic test_overrun();
        int d0;
        int o0;
        d0 = done_cnt;
        o0 = ovr_cnt;
        send_pulse(8'h23);
        fork
            check_frame(8'h23, FRAME_CYC, "overrun_frame");
            begin
                repeat (50) @(posedge clk_in);
                #1;
                tx_ready = 1'b1;
                move = 8'h10;
                @(posedge clk_in); #1;
                tx_ready = 1'b0;
            end
        join
        check_done_cycle("overrun");
        checks++;
        if (ovr_cnt - o0 !== 1 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL overrun_counts: ovr=%0d done=%0d, required 1 1", ovr_cnt - o0, done_cnt - d0);
        end
        repeat (20) begin
            @(negedge clk_in);
            checks++;
            if (busy !== 1'b0 || uart_tx !== 1'b1) begin
                failures++;
                $display("FAIL overrun_no_extra: busy=%b tx=%b, required 0 1", busy, uart_tx);
            end
        end
    endtask

    task automatic test_mid_reset();
        int d0;
        d0 = done_cnt;
        send_pulse(8'h5C);
        check_frame(8'h5C, 40, "pre_reset");
        @(posedge clk_in); #1;
        reset = 1'b1;
        tx_ready = 1'b1;
        move = 8'h77;
        @(posedge clk_in); #1;
        reset = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk_in);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: tx=%b busy=%b done=%b, required 1 0 0", uart_tx, busy, done);
        end
        repeat (15) begin
            @(negedge clk_in);
            checks++;
            if (busy !== 1'b0 || uart_tx !== 1'b1) begin
                failures++;
                $display("FAIL reset_quiet: busy=%b tx=%b, required 0 1", busy, uart_tx);
            end
        end
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        test_fixed(8'h23, "after_reset");
    endtask

    task automatic test_back_to_back();
        send_pulse(8'h23);
        check_frame(8'h23, FRAME_CYC, "b2b_first");
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        move = 8'h42;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: done=%b busy=%b tx=%b, required 1 0 1", done, busy, uart_tx);
        end
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
        move = 8'h99;
        check_frame(8'h42, FRAME_CYC, "b2b_second");
        check_done_cycle("b2b_second");
    endtask

    task automatic test_random();
        logic [7:0] m;
        for (int t = 0; t < 6; t++) begin
            m = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) @(posedge clk_in);
            test_fixed(m, "random");
        end
    endtask

    initial begin
        test_reset();
        test_fixed(8'h23, "move_23");
        test_fixed(8'hFF, "pass_ff");
        test_overrun();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_uart_tx.md
MOVE_UART_TX -- requirements
Module: move_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clk_in cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter HEADER, default 8'hA5, SHALL set the frame header byte.
REQ-003 Port clk_in  input  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port tx_ready  input  1  SHALL be the send request: a one-cycle pulse from the game FSM when the local player's move must go to the opponent.
REQ-006 Port move  input  8  SHALL carry the move byte (8'hFF = pass), sampled only in the cycle tx_ready is accepted.
REQ-007 Port uart_tx  output  1  SHALL be the serial line: 8N1, LSB first, idle high.
REQ-008 Port busy  output  1  SHALL be high while a frame is in flight.
REQ-009 Port done  output  1  SHALL pulse high for one cycle when a frame completes.
REQ-010 Port overrun  output  1  SHALL pulse high for one cycle when tx_ready arrives while busy.

Function
REQ-011 Frame order SHALL be HEADER, then move, then checksum = HEADER XOR move.
REQ-012 Each byte SHALL be one start bit (0), 8 data bits LSB first, and one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-013 States SHALL be IDLE, START, DATA, STOP; a byte index (0..2) SHALL select the byte; a bit index (0..7) SHALL select the data bit.
REQ-014 IDLE: uart_tx=1, busy=0; on tx_ready=1 the block SHALL latch move, clear byte index and enter START.
REQ-015 Latency: when tx_ready is sampled high at edge k, uart_tx=0 and busy=1 SHALL hold from the cycle after edge k.
REQ-016 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8*CLKS_PER_BIT cycles; STOP -> START for the next byte with no idle gap, or -> IDLE after the last byte.
REQ-017 A 3-byte frame SHALL occupy exactly 30*CLKS_PER_BIT cycles of busy=1.
REQ-018 done SHALL pulse in the first cycle busy is 0 after a frame; no other cycle SHALL assert done.
REQ-019 tx_ready while busy=1 SHALL be ignored: the frame in flight and the latched move SHALL be unaffected, and overrun SHALL pulse the next cycle.
REQ-020 tx_ready in the cycle done pulses SHALL be accepted as a new frame; back-to-back frames SHALL be separated only by that one idle-high cycle.
REQ-021 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload on every bit boundary; no drift SHALL accumulate across a frame.
REQ-022 Changes on move after acceptance SHALL NOT alter transmitted data.

Reset
REQ-023 Reset SHALL force state IDLE, uart_tx=1, busy=0, done=0, overrun=0, and clear all counters and the move latch.
REQ-024 Reset asserted mid-frame SHALL abort the frame on the next edge (uart_tx=1) and SHALL NOT produce done.
REQ-025 tx_ready in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro MOVE_TX_CHECKSUM_EN defined: frames SHALL be 3 bytes (HEADER, move, checksum), 30*CLKS_PER_BIT cycles.
REQ-027 Macro MOVE_TX_CHECKSUM_EN undefined: frames SHALL be 2 bytes (HEADER, move), 20*CLKS_PER_BIT cycles, with no checksum logic; all other behaviour SHALL be unchanged.

Verification (CLKS_PER_BIT=4, MOVE_TX_CHECKSUM_EN defined unless stated)
REQ-028 tx_ready pulse with move=8'h23 -> uart_tx carries bytes A5, 23, 86 LSB first with correct start/stop bits; busy high for exactly 120 cycles; one done pulse.
REQ-029 Pass move=8'hFF -> bytes A5, FF, 5A; done after 120 cycles.
REQ-030 Second tx_ready (move=8'h10) 50 cycles into a frame -> overrun pulses once; the frame completes with the original move; no extra frame is sent.
REQ-031 Reset asserted 40 cycles into a frame -> uart_tx=1, busy=0 on the next cycle; no done; a new tx_ready then sends a complete, correct frame.
REQ-032 tx_ready in the done cycle (move=8'h42) -> a second frame A5, 42, E7 starts after exactly one idle-high cycle.
REQ-033 MOVE_TX_CHECKSUM_EN undefined, move=8'h23 -> bytes A5, 23 only; busy high for exactly 80 cycles.
